// File: rtl/reg_file_wb_pkg.sv
// Shared constants and the hazard helper for the write-back register file.
package reg_file_wb_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 1 << AW;

    localparam logic [AW-1:0] REG_ZERO = '0;

    // Outstanding-write check for one register address. A same-cycle write-back
    // to that address is forwarded by the bypass, so it no longer blocks.
    function automatic logic pend_block(
        input logic [AW-1:0] addr,
        input logic          pend_bit,
        input logic          we,
        input logic [AW-1:0] wa
    );
        return (addr != REG_ZERO) && pend_bit && !(we && (wa == addr));
    endfunction

endpackage

// File: rtl/reg_file_wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// write-back, with a registered population count and the issue-stall decision.
module reg_scoreboard
    import reg_file_wb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_wa,
    output logic          hazard,
    output logic [AW:0]   pend_cnt
);

    logic [NREGS-1:0] pend_q, pend_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             raw_a, raw_b, waw;
    logic             iss_set;

    // Stall when either source or the destination still waits on an older writer.
    always_comb begin
        raw_a   = pend_block(ra_a,   pend_q[ra_a],   we, wa);
        raw_b   = pend_block(ra_b,   pend_q[ra_b],   we, wa);
        waw     = pend_block(iss_wa, pend_q[iss_wa], we, wa);
        hazard  = iss_valid && (raw_a || raw_b || waw);
        iss_set = iss_valid && !hazard && (iss_wa != REG_ZERO);
    end

    // Next pending set: clear applied first so a same-index set overrides it.
    always_comb begin
        pend_d = pend_q;
        if (we && (wa != REG_ZERO))
            pend_d[wa] = 1'b0;
        if (iss_set)
            pend_d[iss_wa] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // Population count of the next state so the registered count tracks pend_q.
    always_comb begin
        cnt_d = '0;
        for (int i = 1; i < NREGS; i++)
            cnt_d = cnt_d + (AW+1)'(pend_d[i]);
    end

    // Scoreboard state and count; reset overrides any set or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_wb.sv
// Write-back end of the register path: 2R/1W register file with write-through
// bypass, plus the pending-write scoreboard used by issue to stall.
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_wa,
    output logic          hazard,
    output logic [AW:0]   pend_cnt
);

    logic [DW-1:0] regs_q [NREGS];

    // Storage: entry 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (we && (wa != REG_ZERO)) begin
            regs_q[wa] <= wd;
        end
    end

    // Read ports: zero register, then same-cycle write forwarding, then storage.
    always_comb begin
        if (ra_a == REG_ZERO)
            rd_a = '0;
        else if (we && (wa == ra_a))
            rd_a = wd;
        else
            rd_a = regs_q[ra_a];

        if (ra_b == REG_ZERO)
            rd_b = '0;
        else if (we && (wa == ra_b))
            rd_b = wd;
        else
            rd_b = regs_q[ra_b];
    end

    reg_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .ra_a      (ra_a),
        .ra_b      (ra_b),
        .we        (we),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .hazard    (hazard),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus random traffic
// compared against a plain array model of registers and pending bits.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ra_a = '0, ra_b = '0, wa = '0, iss_wa = '0;
    logic [31:0] wd = '0;
    logic        we = 1'b0, iss_valid = 1'b0;
    logic [31:0] rd_a, rd_b;
    logic        hazard;
    logic [5:0]  pend_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    reg_file_wb dut (
        .clk       (clk),
        .rst       (rst),
        .ra_a      (ra_a),
        .ra_b      (ra_b),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .hazard    (hazard),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit m_waiting(input logic [4:0] a);
        return (a != 0) && m_pend[a] && !(we && wa == a);
    endfunction

    function automatic bit m_hazard();
        return iss_valid && (m_waiting(ra_a) || m_waiting(ra_b) || m_waiting(iss_wa));
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_pend[i] ? 1 : 0;
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic m_tick();
        bit hz;
        hz = m_hazard();
        if (rst) begin
            m_clear();
        end else begin
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_pend[wa] = 1'b0;
            end
            if (iss_valid && !hz && iss_wa != 0)
                m_pend[iss_wa] = 1'b1;
        end
    endtask

    // One cycle: compare combinational outputs against the model, clock, advance model.
    task automatic cyc();
        #2;
        chk("rd_a", rd_a, m_read(ra_a));
        chk("rd_b", rd_b, m_read(ra_b));
        chk("hazard", hazard, m_hazard());
        chk("pend_cnt", pend_cnt, m_count());
        @(posedge clk);
        m_tick();
        #1;
    endtask

    task automatic idle();
        rst = 0; we = 0; wa = 0; wd = 0;
        ra_a = 0; ra_b = 0; iss_valid = 0; iss_wa = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(posedge clk);
        m_clear();
        #1;
        rst = 0;
    endtask

    initial begin
        m_clear();
        // Power-up: two reset cycles with undefined prior state, no compares.
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle();
        chk("post_reset_rd_a", rd_a, 32'h0);
        chk("post_reset_hazard", hazard, 1'b0);
        chk("post_reset_cnt", pend_cnt, 6'd0);

        // 1: random writes/issues, then reset clears everything.
        for (int i = 0; i < 12; i++) begin
            we = 1; wa = 5'($urandom_range(1, 31)); wd = $urandom;
            iss_valid = 1; iss_wa = 5'($urandom_range(1, 31));
            cyc();
        end
        idle();
        rst = 1;
        cyc();
        rst = 0;
        for (int r = 1; r < 32; r += 2) begin
            ra_a = 5'(r); ra_b = 5'(r + 1);
            #1;
            chk("t1_rd_a", rd_a, 32'h0);
            chk("t1_rd_b", rd_b, 32'h0);
            cyc();
        end
        chk("t1_cnt", pend_cnt, 6'd0);

        // 2: write to r0 discarded; bypass and commit on r5.
        idle();
        we = 1; wa = 0; wd = 32'hDEADBEEF; ra_a = 0;
        #1 chk("t2_r0_wr", rd_a, 32'h0);
        cyc();
        idle();
        #1 chk("t2_r0_rd", rd_a, 32'h0);
        cyc();
        we = 1; wa = 5; wd = 32'hDEADBEEF; ra_a = 5;
        #1 chk("t2_bypass", rd_a, 32'hDEADBEEF);
        cyc();
        idle(); ra_a = 5;
        #1 chk("t2_stored", rd_a, 32'hDEADBEEF);
        cyc();

        // 3: RAW stall on r8 resolved by same-cycle write-back.
        do_reset();
        iss_valid = 1; iss_wa = 8;
        cyc();
        idle();
        #1 chk("t3_cnt1", pend_cnt, 6'd1);
        iss_valid = 1; iss_wa = 10; ra_b = 8;
        #1 chk("t3_raw", hazard, 1'b1);
        cyc();
        we = 1; wa = 8; wd = 32'h1234_5678;
        #1 chk("t3_bypass_nohz", hazard, 1'b0);
        chk("t3_rd_b", rd_b, 32'h1234_5678);
        cyc();
        idle();
        #1 chk("t3_cnt_after", pend_cnt, 6'd1);

        // 4: WAW on r9 resolved by bypass; set wins over clear.
        do_reset();
        iss_valid = 1; iss_wa = 9;
        cyc();
        iss_valid = 1; iss_wa = 9; we = 1; wa = 9; wd = 32'hA5A5_0009;
        #1 chk("t4_waw_bypass", hazard, 1'b0);
        cyc();
        idle();
        #1 chk("t4_cnt", pend_cnt, 6'd1);
        iss_valid = 1; iss_wa = 9;
        #1 chk("t4_pend9_held", hazard, 1'b1);
        cyc();

        // 5: fill all 31 pending bits, r0 issue is ignored, drain by write-back.
        do_reset();
        for (int r = 1; r < 32; r++) begin
            iss_valid = 1; iss_wa = 5'(r);
            cyc();
        end
        idle();
        #1 chk("t5_full", pend_cnt, 6'd31);
        iss_valid = 1; iss_wa = 0;
        #1 chk("t5_r0_nohz", hazard, 1'b0);
        cyc();
        idle();
        #1 chk("t5_full_still", pend_cnt, 6'd31);
        for (int r = 1; r < 32; r++) begin
            we = 1; wa = 5'(r); wd = 32'(r * 3);
            cyc();
        end
        idle();
        #1 chk("t5_empty", pend_cnt, 6'd0);

        // 6: reset mid-operation dominates write and issue.
        do_reset();
        we = 1; wa = 3; wd = 32'hCAFE_0003; iss_valid = 1; iss_wa = 3;
        cyc();
        rst = 1; we = 1; wa = 3; wd = 32'h5555_AAAA; iss_valid = 1; iss_wa = 4;
        cyc();
        idle(); ra_a = 3; iss_valid = 1; iss_wa = 3;
        #1 chk("t6_reg3", rd_a, 32'h0);
        chk("t6_cnt", pend_cnt, 6'd0);
        chk("t6_hazard", hazard, 1'b0);
        cyc();

        // Random traffic on a narrow address window to provoke hazards.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            ra_a      = 5'($urandom_range(0, 7));
            ra_b      = 5'($urandom_range(0, 7));
            we        = 1'($urandom_range(0, 1));
            wa        = 5'($urandom_range(0, 7));
            wd        = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_wa    = 5'($urandom_range(0, 7));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
